// File: rtl/i_deser_sdr.sv
// i_deser_sdr -- input-side serial-to-parallel capture (single data rate).
//
// Collects one serial bit per CLK from the input buffer into a WIDTH-bit
// word and presents each finished word on Q with a one-cycle DATA_VALID
// strobe. BITSLIP lets fabric training logic move the word boundary one
// bit later per rising edge of the request.
//
// Ports:
//   CLK        in   1      bit clock, rising edge only
//   RST        in   1      synchronous active-low reset
//   EN         in   1      capture enable; 0 freezes the datapath
//   D          in   1      serial data from the input buffer
//   BITSLIP    in   1      boundary-shift request, rising-edge sensitive
//   Q          out  WIDTH  last completed word (held between strobes)
//   DATA_VALID out  1      one-cycle strobe marking a new word on Q
//
// Parameters:
//   WIDTH      word width, 3..10
//   BIT_ORDER  "MSB_FIRST" (first bit lands in Q[WIDTH-1]) or
//              "LSB_FIRST" (first bit lands in Q[0])

module i_deser_sdr #(
  parameter int    WIDTH     = 4,
  parameter string BIT_ORDER = "MSB_FIRST"
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             D,
  input  logic             BITSLIP,
  output logic [WIDTH-1:0] Q,
  output logic             DATA_VALID
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam bit            LSB_FIRST = (BIT_ORDER == "LSB_FIRST");

  // Reject illegal configurations at elaboration.
  if ((WIDTH < 3) || (WIDTH > 10)) begin : g_bad_width
    $fatal(1, "%m: WIDTH=%0d is illegal; legal values are 3,4,5,6,7,8,9,10", WIDTH);
  end
  if ((BIT_ORDER != "MSB_FIRST") && (BIT_ORDER != "LSB_FIRST")) begin : g_bad_order
    $fatal(1, "%m: BIT_ORDER=\"%s\" is illegal; legal values are \"MSB_FIRST\", \"LSB_FIRST\"", BIT_ORDER);
  end

  logic [WIDTH-1:0] sr_r;
  logic [CW-1:0]    cnt_r;
  logic             bs_q_r;
  logic             slip_pending_r;
  logic [WIDTH-1:0] q_r;
  logic             data_valid_r;

  logic             slip_rise_s;
  logic [WIDTH-1:0] sr_shift_s;
  logic [WIDTH-1:0] sr_nxt_s;
  logic [CW-1:0]    cnt_nxt_s;
  logic             pend_nxt_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic             dv_nxt_s;

  // Next-state decode: shift, slip consume, word completion.
  always_comb begin
    slip_rise_s = BITSLIP & ~bs_q_r;

    if (LSB_FIRST) begin
      sr_shift_s = {D, sr_r[WIDTH-1:1]};
    end else begin
      sr_shift_s = {sr_r[WIDTH-2:0], D};
    end

    sr_nxt_s   = sr_r;
    cnt_nxt_s  = cnt_r;
    pend_nxt_s = slip_pending_r;
    q_nxt_s    = q_r;
    dv_nxt_s   = 1'b0;

    if (EN) begin
      sr_nxt_s = sr_shift_s;
      if (slip_pending_r) begin
        // The bit is absorbed without advancing cnt, so the boundary moves
        // one bit later. A fresh request on this same edge is dropped.
        pend_nxt_s = 1'b0;
      end else begin
        pend_nxt_s = slip_rise_s;
        if (cnt_r == CNT_MAX) begin
          cnt_nxt_s = {CW{1'b0}};
          q_nxt_s   = sr_shift_s;
          dv_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
    end else begin
      // Edge detect keeps running while capture is frozen.
      pend_nxt_s = slip_pending_r | slip_rise_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sr_r           <= {WIDTH{1'b0}};
      cnt_r          <= {CW{1'b0}};
      bs_q_r         <= 1'b0;
      slip_pending_r <= 1'b0;
      q_r            <= {WIDTH{1'b0}};
      data_valid_r   <= 1'b0;
    end else begin
      sr_r           <= sr_nxt_s;
      cnt_r          <= cnt_nxt_s;
      bs_q_r         <= BITSLIP;
      slip_pending_r <= pend_nxt_s;
      q_r            <= q_nxt_s;
      data_valid_r   <= dv_nxt_s;
    end
  end

  assign Q          = q_r;
  assign DATA_VALID = data_valid_r;

endmodule

// File: tb/tb_i_deser_sdr.sv
// tb_i_deser_sdr -- directed bench for i_deser_sdr (WIDTH=4).
//
// Two instances share every input: one MSB_FIRST, one LSB_FIRST. Because
// both see the same enabled bit stream, the LSB_FIRST word is always the
// bit-reverse of the MSB_FIRST word and both strobe on the same cycle.
// Each step drives inputs, waits one rising edge, then checks 1 time unit
// later against hand-computed values.

module tb_i_deser_sdr;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b0;
  logic       D = 1'b0;
  logic       BITSLIP = 1'b0;
  logic [3:0] q_msb;
  logic [3:0] q_lsb;
  logic       dv_msb;
  logic       dv_lsb;

  int n_checks = 0;
  int n_errors = 0;
  int row = 0;

  i_deser_sdr #(.WIDTH(4), .BIT_ORDER("MSB_FIRST")) dut_msb (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .BITSLIP(BITSLIP),
    .Q(q_msb), .DATA_VALID(dv_msb)
  );

  i_deser_sdr #(.WIDTH(4), .BIT_ORDER("LSB_FIRST")) dut_lsb (
    .CLK(CLK), .RST(RST), .EN(EN), .D(D), .BITSLIP(BITSLIP),
    .Q(q_lsb), .DATA_VALID(dv_lsb)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, check both instances.
  task automatic step(input logic rst, input logic en, input logic d, input logic bs,
                      input logic exp_dv, input logic [3:0] exp_q);
    RST = rst; EN = en; D = d; BITSLIP = bs;
    @(posedge CLK);
    #1;
    chk($sformatf("row%0d_msb_dv", row), {31'd0, dv_msb}, {31'd0, exp_dv});
    chk($sformatf("row%0d_msb_q", row), {28'd0, q_msb}, {28'd0, exp_q});
    chk($sformatf("row%0d_lsb_dv", row), {31'd0, dv_lsb}, {31'd0, exp_dv});
    chk($sformatf("row%0d_lsb_q", row), {28'd0, q_lsb}, {28'd0, rev4(exp_q)});
    row++;
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    // First word 1,0,1,1: strobe after the 4th edge
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
    // Second aligned word, Q held meanwhile
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
    // One-cycle BITSLIP pulse: strobe one cycle late, words become 0111
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0111);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0111);
    // Second pulse: words become 1110
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1110);
    // BITSLIP held for 10 cycles: exactly one shift, words 1101
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1110);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1110);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1110);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1110);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1101);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1101);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1101);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1101);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1101);
    // Second rising edge while pending (EN=0 gap): ignored, one shift -> 1011
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1101);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1101);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1101);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1101);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
    // Rising edge on the consume edge is dropped: one shift -> 0111
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1011);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0111);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0111);
    // EN gap of 3 cycles after bit 2 of 1011: same word, strobe 3 cycles late
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1011);
    // Reset after 2 bits: partial word discarded, then 0,1,1,0 -> 0110
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0110);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0110);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
